// File: rtl/multi_channel_replay_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : replay_pkg
// Description : Shared types and default parameter constants for the
//               multi-channel ping-pong replay buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package replay_pkg;

  // Replay controller states
  typedef enum logic [0:0] {
    RB_IDLE   = 1'b0,
    RB_REPLAY = 1'b1
  } rb_state_t;

  // Default parameter values shared by interface, bank and top
  localparam int c_def_p      = 64;
  localparam int c_def_num_ch = 2;
  localparam int c_def_depth  = 16;

endpackage : replay_pkg
`default_nettype wire

// File: rtl/multi_channel_replay_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_replay_buffer_if
// Description : Capture/replay bus of the replay buffer. The master side
//               feeds time steps and gamma ticks and consumes replay beats;
//               the slave side is the buffer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_channel_replay_buffer_if
  import replay_pkg::*;
#(
  parameter int P      = c_def_p,
  parameter int NUM_CH = c_def_num_ch,
  parameter int DEPTH  = c_def_depth
) ();

  localparam int c_ch_w   = $clog2(NUM_CH);
  localparam int c_step_w = $clog2(DEPTH);

  logic                  gamma_tick;
  logic                  in_valid;
  logic [NUM_CH*P-1:0]   in_data;
  logic                  out_ready;
  logic                  out_valid;
  logic [P-1:0]          out_data;
  logic [c_ch_w-1:0]     out_ch;
  logic [c_step_w-1:0]   out_step;
  logic                  out_last;
  logic                  busy;
  logic                  overflow;
  logic                  overrun;

  modport master (
    output gamma_tick, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_ch, out_step, out_last, busy, overflow, overrun
  );

  modport slave (
    input  gamma_tick, in_valid, in_data, out_ready,
    output out_valid, out_data, out_ch, out_step, out_last, busy, overflow, overrun
  );

endinterface : multi_channel_replay_buffer_if
`default_nettype wire

// File: rtl/multi_channel_replay_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module      : replay_bank
// Description : One NUM_CH x DEPTH x P storage bank. A write stores a whole
//               time step (all channels); the read port returns one channel
//               of one step, registered. Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module replay_bank
  import replay_pkg::*;
#(
  parameter int P      = c_def_p,
  parameter int NUM_CH = c_def_num_ch,
  parameter int DEPTH  = c_def_depth
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_step,
  input  logic [NUM_CH*P-1:0]        wr_data,
  input  logic [$clog2(NUM_CH)-1:0]  rd_ch,
  input  logic [$clog2(DEPTH)-1:0]   rd_step,
  output logic [P-1:0]               rd_data
);

  logic [NUM_CH*P-1:0] r_mem [DEPTH];
  logic [NUM_CH*P-1:0] w_rd_row;
  logic [P-1:0]        r_rd_data;

  assign w_rd_row = r_mem[rd_step];
  assign rd_data  = r_rd_data;

  // Step-wide write and registered single-channel read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_step] <= wr_data;
    end
    r_rd_data <= w_rd_row[rd_ch*P +: P];
  end

endmodule : replay_bank
`default_nettype wire

// File: rtl/multi_channel_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_replay_buffer
// Description : Ping-pong capture of NUM_CH spike channels per gamma cycle;
//               on each gamma_tick the filled bank is replayed channel by
//               channel, step by step, over a valid/ready stream while the
//               other bank captures the next gamma cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_replay_buffer
  import replay_pkg::*;
#(
  parameter int P      = c_def_p,
  parameter int NUM_CH = c_def_num_ch,
  parameter int DEPTH  = c_def_depth
) (
  input  logic                          clk,
  input  logic                          grst,
  multi_channel_replay_buffer_if.slave  bus
);

  localparam int c_ch_w   = $clog2(NUM_CH);
  localparam int c_step_w = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);

  localparam logic [c_ch_w-1:0]   c_last_ch   = c_ch_w'(NUM_CH - 1);
  localparam logic [c_step_w-1:0] c_last_step = c_step_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0]  c_depth_cnt = c_cnt_w'(DEPTH);

  rb_state_t             r_state,       w_state_nxt;
  logic                  r_fill_bank,   w_fill_bank_nxt;
  logic [c_cnt_w-1:0]    r_fill_cnt,    w_fill_cnt_nxt;
  logic [c_cnt_w-1:0]    r_rvalid_cnt,  w_rvalid_cnt_nxt;
  logic [c_ch_w-1:0]     r_ch,          w_ch_nxt;
  logic [c_step_w-1:0]   r_step,        w_step_nxt;
  logic                  r_out_valid,   w_out_valid_nxt;
  logic                  r_out_last,    w_out_last_nxt;
  logic                  r_zero,        w_zero_nxt;
  logic                  r_overflow,    w_overflow_nxt;
  logic                  r_overrun,     w_overrun_nxt;

  logic                  w_hs;
  logic                  w_at_last;
  logic                  w_wr_en;
  logic                  w_wr_bank;
  logic [c_step_w-1:0]   w_wr_step;
  logic                  w_replay_bank;
  logic [P-1:0]          w_rd_data [2];

  assign w_hs          = r_out_valid && bus.out_ready;
  assign w_at_last     = (r_ch == c_last_ch) && (r_step == c_last_step);
  assign w_replay_bank = ~r_fill_bank;

  // Next-state, fill and replay-pointer logic
  always_comb begin
    w_state_nxt      = r_state;
    w_fill_bank_nxt  = r_fill_bank;
    w_fill_cnt_nxt   = r_fill_cnt;
    w_rvalid_cnt_nxt = r_rvalid_cnt;
    w_ch_nxt         = r_ch;
    w_step_nxt       = r_step;
    w_overflow_nxt   = r_overflow;
    w_overrun_nxt    = r_overrun;
    w_wr_en          = 1'b0;
    w_wr_bank        = r_fill_bank;
    w_wr_step        = '0;

    // Advance the replay pointer on each accepted beat
    if (r_state == RB_REPLAY && w_hs) begin
      if (w_at_last) begin
        w_state_nxt = RB_IDLE;
        w_ch_nxt    = '0;
        w_step_nxt  = '0;
      end else if (r_step == c_last_step) begin
        w_step_nxt = '0;
        w_ch_nxt   = r_ch + 1'b1;
      end else begin
        w_step_nxt = r_step + 1'b1;
      end
    end

    if (bus.gamma_tick) begin
      // A tick landing on the handshake of the final beat is not an overrun:
      // that replay completes in the same cycle.
      if (r_state == RB_REPLAY && !(w_hs && w_at_last)) begin
        w_overrun_nxt = 1'b1;
      end
      w_state_nxt      = RB_REPLAY;
      w_ch_nxt         = '0;
      w_step_nxt       = '0;
      w_fill_bank_nxt  = ~r_fill_bank;
      w_rvalid_cnt_nxt = r_fill_cnt;
      w_wr_bank        = ~r_fill_bank;
      if (bus.in_valid) begin
        w_wr_en        = 1'b1;
        w_fill_cnt_nxt = c_cnt_w'(1);
      end else begin
        w_fill_cnt_nxt = '0;
      end
    end else if (bus.in_valid) begin
      if (r_fill_cnt < c_depth_cnt) begin
        w_wr_en        = 1'b1;
        w_wr_step      = r_fill_cnt[c_step_w-1:0];
        w_fill_cnt_nxt = r_fill_cnt + c_cnt_w'(1);
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end

    w_out_valid_nxt = (w_state_nxt == RB_REPLAY);
    w_out_last_nxt  = (w_state_nxt == RB_REPLAY) && (w_ch_nxt == c_last_ch) &&
                      (w_step_nxt == c_last_step);
    // Steps past the captured count replay as zero so stale data never leaks
    w_zero_nxt      = (c_cnt_w'(w_step_nxt) >= w_rvalid_cnt_nxt);
  end

  // State and output registers
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_state      <= RB_IDLE;
      r_fill_bank  <= 1'b0;
      r_fill_cnt   <= '0;
      r_rvalid_cnt <= '0;
      r_ch         <= '0;
      r_step       <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_zero       <= 1'b1;
      r_overflow   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_bank  <= w_fill_bank_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_rvalid_cnt <= w_rvalid_cnt_nxt;
      r_ch         <= w_ch_nxt;
      r_step       <= w_step_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_zero       <= w_zero_nxt;
      r_overflow   <= w_overflow_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // Both banks read the upcoming beat address so data lands with the pointer
  for (genvar b = 0; b < 2; b++) begin : g_bank
    replay_bank #(
      .P      (P),
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (w_wr_en && (w_wr_bank == 1'(b))),
      .wr_step (w_wr_step),
      .wr_data (bus.in_data),
      .rd_ch   (w_ch_nxt),
      .rd_step (w_step_nxt),
      .rd_data (w_rd_data[b])
    );
  end

  // Output data is a select between registered values only
  assign bus.out_data  = (r_out_valid && !r_zero) ? w_rd_data[w_replay_bank] : '0;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_ch;
  assign bus.out_step  = r_step;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state == RB_REPLAY);
  assign bus.overflow  = r_overflow;
  assign bus.overrun   = r_overrun;

endmodule : multi_channel_replay_buffer
`default_nettype wire

// File: tb/tb_multi_channel_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_replay_buffer
// Description : Directed and randomized bench for the replay buffer with a
//               queue-based reference model (P=8, NUM_CH=2, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_replay_buffer;

  localparam int P      = 8;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [7:0] d;
    int         ch;
    int         st;
    bit         last;
  } beat_t;

  logic clk;
  logic grst;

  multi_channel_replay_buffer_if #(.P(P), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

  multi_channel_replay_buffer #(.P(P), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .grst (grst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  beat_t       m_q[$];
  logic [15:0] m_fill[$];
  bit          m_ovf = 0;
  bit          m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Turn the captured steps into the expected replay sequence
  task automatic model_tick();
    if (m_q.size() != 0) m_ovr = 1;
    m_q = {};
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < DEPTH; s++) begin
        beat_t       b;
        logic [15:0] row;
        row    = (s < m_fill.size()) ? m_fill[s] : 16'h0000;
        b.d    = row[c*8 +: 8];
        b.ch   = c;
        b.st   = s;
        b.last = (c == NUM_CH - 1) && (s == DEPTH - 1);
        m_q.push_back(b);
      end
    end
    m_fill = {};
  endtask

  // One clock: drive, check present outputs, advance model, step the clock
  task automatic cycle(input bit tick, input bit vld, input logic [15:0] dat, input bit rdy);
    bus.gamma_tick = tick;
    bus.in_valid   = vld;
    bus.in_data    = dat;
    bus.out_ready  = rdy;
    chk("out_valid", bus.out_valid, m_q.size() != 0);
    chk("busy", bus.busy, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_data", bus.out_data, m_q[0].d);
      chk("out_ch", bus.out_ch, m_q[0].ch);
      chk("out_step", bus.out_step, m_q[0].st);
      chk("out_last", bus.out_last, m_q[0].last);
      if (rdy) void'(m_q.pop_front());
    end
    chk("overflow", bus.overflow, m_ovf);
    chk("overrun", bus.overrun, m_ovr);
    if (tick) model_tick();
    if (vld) begin
      if (m_fill.size() < DEPTH) m_fill.push_back(dat);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && m_q.size() != 0; k++) cycle(0, 0, 16'h0, 1);
    chk("drained", m_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_ch"}, bus.out_ch, 0);
    chk({tag, "_step"}, bus.out_step, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_ovr"}, bus.overrun, 0);
  endtask

  initial begin
    int hs;
    int stall;
    int beats;
    grst           = 1'b1;
    bus.gamma_tick = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    grst = 1'b0;
    cycle(0, 0, 16'h0, 1);

    // Full capture then in-order replay
    cycle(0, 1, 16'h1101, 1);
    cycle(0, 1, 16'h1202, 1);
    cycle(0, 1, 16'h1303, 1);
    cycle(0, 1, 16'h1404, 1);
    cycle(1, 0, 16'h0, 1);
    beats = m_q.size();
    chk("full_beats", beats, 8);
    drain();

    // Partial capture: missing steps replay as zero
    cycle(0, 1, 16'hBBAA, 1);
    cycle(0, 1, 16'hDDCC, 1);
    cycle(1, 0, 16'h0, 1);
    drain();

    // Overflow: six writes into a four-step bank
    for (int i = 0; i < 6; i++) cycle(0, 1, 16'(16'h2121 * (i + 1)), 1);
    chk("overflow_set", bus.overflow, 1);
    cycle(1, 0, 16'h0, 1);
    drain();

    // Back-pressure for three cycles at the third beat
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'($urandom), 1);
    cycle(1, 0, 16'h0, 1);
    hs = 0;
    stall = 0;
    for (int k = 0; k < 40 && m_q.size() != 0; k++) begin
      bit r;
      r = !(hs == 2 && stall < 3);
      if (r) hs++;
      else stall++;
      cycle(0, 0, 16'h0, r);
    end
    chk("stall_beats", hs, 8);
    chk("stall_cycles", stall, 3);

    // Overrun: second tick while beat 5 is presented
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'($urandom), 1);
    cycle(1, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'($urandom), 1);
    cycle(0, 0, 16'h0, 1);
    cycle(1, 0, 16'h0, 1);
    chk("overrun_set", bus.overrun, 1);
    chk("restart_step", bus.out_step, 0);
    chk("restart_ch", bus.out_ch, 0);
    drain();

    // Randomized traffic including coincident tick/write
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
            $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset in the middle of a replay
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'($urandom), 1);
    cycle(1, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 1);
    grst = 1'b1;
    #1;
    check_all_zero("midreset");
    m_q    = {};
    m_fill = {};
    m_ovf  = 0;
    m_ovr  = 0;
    @(posedge clk);
    #1;
    grst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 1);
    cycle(1, 0, 16'h0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multi_channel_replay_buffer
`default_nettype wire
